clk_enable_sequencer: RTL
=========================

CLK_ENABLE_SEQUENCER -- requirements
Module: clk_enable_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, master clock (21.477 MHz NTSC / 26.601 MHz PAL-Dendy domain); single clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port sys_type, input, 2, region select: 0 NTSC, 1 PAL, 2 Dendy, 3 reserved (treated as NTSC).
REQ-004 SHALL have port pause, input, 1, freeze request; holds all timing state.
REQ-005 SHALL have port cpu_ce, output, 1, one-clk CPU/DMA clock-enable pulse.
REQ-006 SHALL have port apu_ce, output, 1, APU clock-enable pulse, identical to cpu_ce.
REQ-007 SHALL have port ppu_ce, output, 1, one-clk PPU clock-enable pulse.
REQ-008 SHALL have port phi2, output, 1, M2 level for APU/mapper bus.
REQ-009 SHALL have port odd_or_even, output, 1, CPU-cycle parity for APU/DMA alignment.
REQ-010 SHALL have port ppu_access, output, 1, one-clk strobe marking the PPU register read/write slot.

Function
REQ-011 SHALL keep master counter m, 0..CPU_DIV-1; CPU_DIV = 12 NTSC, 16 PAL, 15 Dendy.
REQ-012 SHALL keep PPU counter p, 0..PPU_DIV-1; PPU_DIV = 4 NTSC, 5 PAL, 5 Dendy; p and m run independently; wrap to 0 after terminal value.
REQ-013 SHALL assert cpu_ce and apu_ce, registered, in the clk where m == CPU_DIV-1.
REQ-014 SHALL assert ppu_ce, registered, in the clk where p == PPU_DIV-1.
REQ-015 SHALL drive phi2 = 1 while m >= PHI2_LO, where PHI2_LO = 4 NTSC, 6 PAL, 5 Dendy; phi2 falls on the clk after cpu_ce.
REQ-016 SHALL toggle odd_or_even on every cpu_ce.
REQ-017 SHALL count ppu_ce pulses since the last cpu_ce in slot index k, 0..3, saturating at 3, cleared by cpu_ce; k = 0 after a coincident cpu_ce and ppu_ce.
REQ-018 SHALL pulse ppu_access together with the ppu_ce that occurs while k == 2, i.e. the third PPU cycle of each CPU cycle, at most once per CPU cycle; PAL extra ppu_ce (k saturated) SHALL NOT pulse.
REQ-019 SHALL latch sys_type into an active-region register only in the clk of cpu_ce; on a change, m and p restart at 0 on the next clk under the new divisors; mid-cycle sys_type changes have no effect until then.
REQ-020 SHALL, while pause = 1, hold m, p, k, odd_or_even, phi2 and the active region, and force cpu_ce, apu_ce, ppu_ce and ppu_access to 0; counting resumes from the held values on the clk after pause falls.
REQ-021 SHALL give pause priority over sys_type latching when both occur in a cpu_ce clk: the latch is deferred to the next unpaused cpu_ce.

Reset
REQ-022 SHALL, on reset assertion (asynchronous), force m = 0, p = 0, k = 0, cpu_ce = apu_ce = ppu_ce = ppu_access = 0, phi2 = 0, odd_or_even = 0.
REQ-023 SHALL load the active region from sys_type continuously while reset = 1; the first cpu_ce occurs CPU_DIV clks after reset release.
REQ-024 SHALL abandon a partially elapsed CPU or PPU cycle on reset mid-operation; no pulse is issued for it.

Configuration
REQ-025 SHALL honour macro CE_SEQ_DENDY_EN: defined, sys_type 2 selects Dendy divisors 15/5, PHI2_LO 5; undefined, sys_type 2 behaves exactly as NTSC and the Dendy constants are not compiled in.

Structure
REQ-026 SHALL place the region enum, CPU_DIV, PPU_DIV and PHI2_LO per region in shared package nes_timing_pkg.
REQ-027 SHALL use one sub-module, ce_divider: a modulo-N counter with hold input, synchronous restart and registered terminal pulse, instantiated twice, for m and p.

Verification
REQ-028 SHALL cover NTSC steady state: reset release, sys_type 0 -> cpu_ce every 12 clks, ppu_ce every 4, ppu_access every 12, phi2 high 8 of 12 clks.
REQ-029 SHALL cover PAL: sys_type 1 -> over 80 clks, 5 cpu_ce and 16 ppu_ce; exactly 5 ppu_access, none on the 4th PPU cycle within a CPU cycle.
REQ-030 SHALL cover region switch: sys_type 0 -> 1 at m = 5 -> divisor stays 12 until the next cpu_ce, then 16/5 with m and p restarted at 0.
REQ-031 SHALL cover pause: pause held for 7 clks at m = 3 -> zero ce pulses during the hold, m = 3 on resume, next cpu_ce 8 clks after pause falls, odd_or_even unchanged.
REQ-032 SHALL cover reset mid-cycle: reset at m = 9 -> all outputs 0 immediately, no cpu_ce until 12 clks after release.
REQ-033 SHALL cover the macro: sys_type 2 with CE_SEQ_DENDY_EN -> cpu_ce every 15 clks; without it -> every 12 clks.

Source files
------------

// File: rtl/nes_timing_pkg.sv
// Shared NES region timing: region encoding and per-region divisors.
// Dendy constants exist only when CE_SEQ_DENDY_EN is defined.
package nes_timing_pkg;

  typedef enum logic [1:0] {
    REGION_NTSC  = 2'd0,
    REGION_PAL   = 2'd1,
    REGION_DENDY = 2'd2
  } region_t;

  localparam int DIV_W = 5;

  typedef struct packed {
    logic [DIV_W-1:0] cpu_div;
    logic [DIV_W-1:0] ppu_div;
    logic [DIV_W-1:0] phi2_lo;
  } timing_t;

  localparam logic [DIV_W-1:0] NTSC_CPU_DIV  = 5'd12;
  localparam logic [DIV_W-1:0] NTSC_PPU_DIV  = 5'd4;
  localparam logic [DIV_W-1:0] NTSC_PHI2_LO  = 5'd4;
  localparam logic [DIV_W-1:0] PAL_CPU_DIV   = 5'd16;
  localparam logic [DIV_W-1:0] PAL_PPU_DIV   = 5'd5;
  localparam logic [DIV_W-1:0] PAL_PHI2_LO   = 5'd6;
`ifdef CE_SEQ_DENDY_EN
  localparam logic [DIV_W-1:0] DENDY_CPU_DIV = 5'd15;
  localparam logic [DIV_W-1:0] DENDY_PPU_DIV = 5'd5;
  localparam logic [DIV_W-1:0] DENDY_PHI2_LO = 5'd5;
`endif

  // Reserved encodings (and Dendy when not built in) fall back to NTSC.
  function automatic region_t decode_region(input logic [1:0] sel);
    region_t r;
    case (sel)
      2'd1: r = REGION_PAL;
`ifdef CE_SEQ_DENDY_EN
      2'd2: r = REGION_DENDY;
`endif
      default: r = REGION_NTSC;
    endcase
    return r;
  endfunction

  function automatic timing_t region_timing(input region_t r);
    timing_t t;
    case (r)
      REGION_PAL: t = '{cpu_div: PAL_CPU_DIV, ppu_div: PAL_PPU_DIV, phi2_lo: PAL_PHI2_LO};
`ifdef CE_SEQ_DENDY_EN
      REGION_DENDY: t = '{cpu_div: DENDY_CPU_DIV, ppu_div: DENDY_PPU_DIV, phi2_lo: DENDY_PHI2_LO};
`endif
      default: t = '{cpu_div: NTSC_CPU_DIV, ppu_div: NTSC_PPU_DIV, phi2_lo: NTSC_PHI2_LO};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Modulo-n counter with hold, synchronous restart and a registered pulse
// that is high exactly while the count sits at its terminal value.
module ce_divider
  import nes_timing_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             restart,
  input  logic [DIV_W-1:0] n,
  output logic [DIV_W-1:0] count,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] count_next;

  assign last = n - ONE;

  always_comb begin
    count_next = count + ONE;
    if (restart || (count == last)) count_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!hold) begin
      count <= count_next;
      tick  <= (count_next == last);
    end
  end

endmodule

// File: rtl/clk_enable_sequencer.sv
// NES master-clock enable sequencer: CPU/APU/PPU enables, M2, parity and the
// PPU register-access slot. Dendy timing is built in with CE_SEQ_DENDY_EN.
module clk_enable_sequencer
  import nes_timing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sys_type,
  input  logic       pause,
  output logic       cpu_ce,
  output logic       apu_ce,
  output logic       ppu_ce,
  output logic       phi2,
  output logic       odd_or_even,
  output logic       ppu_access
);

  logic             run;
  region_t          region_q;
  region_t          region;
  region_t          next_region;
  timing_t          timing;
  logic [DIV_W-1:0] m;
  logic [DIV_W-1:0] p;
  logic             m_tick;
  logic             p_tick;
  logic             hold;
  logic             cpu_slot;
  logic             ppu_slot;
  logic             region_change;
  logic [1:0]       k;
  logic             parity;

  // run stays low for one clk after release so the first cpu_ce lands a full
  // CPU cycle later; until then the region tracks sys_type directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  assign next_region   = decode_region(sys_type);
  assign region        = run ? region_q : next_region;
  assign timing        = region_timing(region);
  assign hold          = pause | ~run;
  assign cpu_slot      = m_tick & ~hold;
  assign ppu_slot      = p_tick & ~hold;
  assign region_change = cpu_slot && (next_region != region_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) region_q <= REGION_NTSC;
    else if (!run || cpu_slot) region_q <= next_region;
  end

  ce_divider u_cpu_div (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .restart (region_change),
    .n       (timing.cpu_div),
    .count   (m),
    .tick    (m_tick)
  );

  ce_divider u_ppu_div (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .restart (region_change),
    .n       (timing.ppu_div),
    .count   (p),
    .tick    (p_tick)
  );

  // k counts PPU cycles inside the current CPU cycle; cpu_ce wins on a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k      <= 2'd0;
      parity <= 1'b0;
    end else if (cpu_slot) begin
      k      <= 2'd0;
      parity <= ~parity;
    end else if (ppu_slot && (k != 2'd3)) begin
      k      <= k + 2'd1;
    end
  end

  assign cpu_ce      = cpu_slot;
  assign apu_ce      = cpu_slot;
  assign ppu_ce      = ppu_slot;
  assign ppu_access  = ppu_slot && (k == 2'd2);
  assign phi2        = (m >= timing.phi2_lo);
  assign odd_or_even = parity;

endmodule
